// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES decipher arbiter: FSM states, key-length
// codes and requester ID width.
package aes_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_RESP     = 3'd3,
        ST_ERR_RESP = 3'd4
    } arb_state_t;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    localparam int unsigned REQ_ID_W = 1;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the last-grant register
// is owned by the parent.
module aes_rr_arb2
    import aes_arb_pkg::*;
(
    input  logic [1:0]          req,
    input  logic [REQ_ID_W-1:0] last_grant,
    output logic [1:0]          grant,
    output logic [REQ_ID_W-1:0] grant_id
);

    // On contention favour the requester that was not served last.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
        if (req != 2'b00) begin
            grant = (grant_id == 1'b1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/aes_decipher_arbiter.sv
// Shares one aes_decipher_block engine between two requesters. Requests are
// granted round-robin, operands are registered and held for the engine, and
// the result (or a watchdog error) is returned on a tagged response channel.
module aes_decipher_arbiter
    import aes_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_block,
    input  logic         req0_keylen,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_block,
    input  logic         req1_keylen,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_block,
    output logic         rsp_error,
    output logic         eng_next,
    output logic         eng_keylen,
    output logic [127:0] eng_block,
    input  logic [127:0] eng_new_block,
    input  logic         eng_ready
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [REQ_ID_W-1:0] last_grant;
    logic [1:0]          grant;
    logic [REQ_ID_W-1:0] grant_id;
    logic                accept;
    logic [CNT_W-1:0]    wd_cnt;
    logic [CNT_W-1:0]    wd_inc;
    logic                timeout_hit;

    aes_rr_arb2 u_rr_arb2 (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    // Saturating watchdog; the incremented value is compared so that the
    // error path is taken after exactly TIMEOUT WAIT cycles.
    always_comb begin
        wd_inc      = (wd_cnt == CNT_W'(TIMEOUT)) ? wd_cnt : wd_cnt + CNT_W'(1);
        timeout_hit = (wd_inc == CNT_W'(TIMEOUT));
    end

    // Acceptance handshake and ready generation (held low during reset).
    always_comb begin
        accept     = (state == ST_IDLE) && eng_ready && (grant != 2'b00);
        req0_ready = (state == ST_IDLE) && eng_ready && grant[0] && !reset;
        req1_ready = (state == ST_IDLE) && eng_ready && grant[1] && !reset;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        eng_next  = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_START;
            end
            ST_START: begin
                eng_next  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_ready)        state_nxt = ST_RESP;
                else if (timeout_hit) state_nxt = ST_ERR_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            ST_ERR_RESP: begin
                rsp_valid = 1'b1;
                rsp_error = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, grant history, watchdog and response data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            eng_block  <= '0;
            eng_keylen <= AES_128_BIT_KEY;
            rsp_id     <= 1'b0;
            rsp_block  <= '0;
            wd_cnt     <= '0;
        end else begin
            if (accept) begin
                eng_block  <= (grant_id == 1'b1) ? req1_block  : req0_block;
                eng_keylen <= (grant_id == 1'b1) ? req1_keylen : req0_keylen;
                rsp_id     <= grant_id;
                last_grant <= grant_id;
            end
            if (state == ST_START) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_inc;
            end
            if (state == ST_WAIT) begin
                if (eng_ready)        rsp_block <= eng_new_block;
                else if (timeout_hit) rsp_block <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aes_decipher_arbiter.sv
// Self-checking bench for aes_decipher_arbiter with a behavioural engine
// stand-in and a response scoreboard.
module tb_aes_decipher_arbiter;
    import aes_arb_pkg::*;

    localparam int unsigned TMO    = 100;
    localparam int unsigned LAT128 = 10;
    localparam int unsigned LAT256 = 14;

    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req0_keylen;
    logic [127:0] req0_block;
    logic         req1_valid, req1_ready, req1_keylen;
    logic [127:0] req1_block;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_error;
    logic [127:0] rsp_block;
    logic         eng_next, eng_keylen, eng_ready;
    logic [127:0] eng_block, eng_new_block;

    always #5 clk = ~clk;

    aes_decipher_arbiter #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_block    (req0_block),
        .req0_keylen   (req0_keylen),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_block    (req1_block),
        .req1_keylen   (req1_keylen),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_block     (rsp_block),
        .rsp_error     (rsp_error),
        .eng_next      (eng_next),
        .eng_keylen    (eng_keylen),
        .eng_block     (eng_block),
        .eng_new_block (eng_new_block),
        .eng_ready     (eng_ready)
    );

    // Engine stand-in: known FIPS-197 vectors decode to PT, anything else
    // maps through a keylen-dependent scramble.
    function automatic logic [127:0] model_pt(input logic [127:0] ct, input logic kl);
        if (kl == AES_128_BIT_KEY && ct == CT128) return PT;
        if (kl == AES_256_BIT_KEY && ct == CT256) return PT;
        return ct ^ {4{32'hA5C3_5A3C}} ^ {128{kl}};
    endfunction

    logic        stall;
    int unsigned eng_cnt;

    // Engine model: keylen sampled at start, block sampled at completion.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_ready     <= 1'b1;
            eng_new_block <= '0;
            eng_cnt       <= 0;
        end else if (eng_ready) begin
            if (eng_next) begin
                eng_ready <= 1'b0;
                eng_cnt   <= (eng_keylen ? LAT256 : LAT128) - 1;
            end
        end else if (!stall) begin
            if (eng_cnt == 0) begin
                eng_ready     <= 1'b1;
                eng_new_block <= model_pt(eng_block, eng_keylen);
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    typedef struct {
        logic         id;
        logic [127:0] blk;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           acc_ids[$];
    int           total = 0;
    int           bad   = 0;
    logic [127:0] pend_blk [2];
    logic         pend_err [2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=expired expected=event", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id);
        exp_t e;
        e.id  = id[0];
        e.blk = pend_blk[id];
        e.err = pend_err[id];
        sb.push_back(e);
        acc_ids.push_back(id);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            fail_now("sb_empty");
        end else begin
            e = sb.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_block", rsp_block, e.blk);
            check("rsp_error", rsp_error, e.err);
        end
    endtask

    // Accept pending requests and retire responses until nrsp are seen.
    task automatic run(input int nrsp);
        int   got   = 0;
        int   guard = 0;
        logic a0, a1;
        while (got < nrsp && guard < 1000) begin
            #1;
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0) push(0);
            if (a1) push(1);
            if (rsp_valid && rsp_ready) begin
                pop_check();
                got++;
            end
            tick();
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
            guard++;
        end
        if (got < nrsp) fail_now("run_budget");
    endtask

    initial begin
        int k;
        logic [127:0] b;

        reset = 1'b1; stall = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_block = '0; req0_keylen = 1'b0;
        req1_valid = 1'b0; req1_block = '0; req1_keylen = 1'b0;
        pend_blk[0] = '0; pend_blk[1] = '0; pend_err[0] = 1'b0; pend_err[1] = 1'b0;
        repeat (3) tick();
        req0_valid = 1'b1;
        #1;
        check("rst_ctrl", {rsp_valid, rsp_error, rsp_id, eng_next, eng_keylen, req0_ready, req1_ready}, 7'b0);
        check("rst_rsp_block", rsp_block, '0);
        check("rst_eng_block", eng_block, '0);
        req0_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Contention from reset: 0 then 1, twice.
        rsp_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            req0_block = b; req0_keylen = 1'b0; pend_blk[0] = model_pt(b, 1'b0);
            b = {$urandom, $urandom, $urandom, $urandom};
            req1_block = b; req1_keylen = 1'b1; pend_blk[1] = model_pt(b, 1'b1);
            req0_valid = 1'b1; req1_valid = 1'b1;
            run(2);
            check("arb_first", acc_ids.size() > 0 ? acc_ids[0] : -1, 0);
            check("arb_second", acc_ids.size() > 1 ? acc_ids[1] : -1, 1);
            acc_ids.delete();
        end

        // Single FIPS-197 AES-128 request with timing.
        req0_block = CT128; req0_keylen = AES_128_BIT_KEY; pend_blk[0] = PT;
        req0_valid = 1'b1;
        #1;
        check("single_ready", req0_ready, 1);
        push(0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("next_t1", eng_next, 1);
        check("eng_keylen_128", eng_keylen, 0);
        check("eng_block_128", eng_block, CT128);
        tick();
        check("next_once", eng_next, 0);
        k = 2;
        while (!rsp_valid && k < 300) begin
            tick();
            k++;
        end
        check("single_latency", k, LAT128 + 3);
        pop_check();
        tick();

        // Backpressure: req1 waits behind a stalled response.
        rsp_ready = 1'b0;
        b = {$urandom, $urandom, $urandom, $urandom};
        req0_block = b; req0_keylen = 1'b0; pend_blk[0] = model_pt(b, 1'b0);
        req0_valid = 1'b1;
        #1;
        check("bp_req0_ready", req0_ready, 1);
        push(0);
        tick();
        req0_valid = 1'b0;
        b = {$urandom, $urandom, $urandom, $urandom};
        req1_block = b; req1_keylen = 1'b0; pend_blk[1] = model_pt(b, 1'b0);
        req1_valid = 1'b1;
        k = 0;
        while (!rsp_valid && k < 300) begin
            tick();
            k++;
        end
        if (!rsp_valid) fail_now("bp_rsp_wait");
        for (int i = 0; i < 20; i++) begin
            check("bp_ctrl", {rsp_valid, rsp_id, req1_ready}, 3'b100);
            check("bp_block", rsp_block, pend_blk[0]);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        pop_check();
        check("bp_req1_blocked", req1_ready, 0);
        tick();
        check("bp_req1_after", req1_ready, 1);
        run(1);

        // Watchdog timeout with the engine stalled.
        stall = 1'b1;
        pend_blk[1] = '0; pend_err[1] = 1'b1;
        req1_block = {$urandom, $urandom, $urandom, $urandom};
        req1_valid = 1'b1;
        #1;
        check("to_ready", req1_ready, 1);
        push(1);
        tick();
        req1_valid = 1'b0;
        #1;
        check("to_next", eng_next, 1);
        k = 0;
        while (!rsp_valid && k < 300) begin
            tick();
            k++;
        end
        check("to_wait_cycles", k, TMO + 1);
        pop_check();
        tick();
        stall = 1'b0;
        pend_err[1] = 1'b0;

        // Reset in the middle of an operation.
        b = {$urandom, $urandom, $urandom, $urandom};
        req0_block = b; req0_keylen = 1'b0; pend_blk[0] = model_pt(b, 1'b0);
        req0_valid = 1'b1;
        #1;
        k = 0;
        while (!req0_ready && k < 50) begin
            tick();
            k++;
        end
        if (!req0_ready) fail_now("mid_ready_wait");
        push(0);
        tick();
        req0_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mid_rst_ctrl", {rsp_valid, rsp_error, rsp_id, eng_next, eng_keylen, req0_ready, req1_ready}, 7'b0);
        check("mid_rst_rsp_block", rsp_block, '0);
        check("mid_rst_eng_block", eng_block, '0);
        sb.delete();
        acc_ids.delete();
        req1_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Fresh FIPS-197 AES-256 request after reset.
        req1_block = CT256; req1_keylen = AES_256_BIT_KEY; pend_blk[1] = PT;
        req1_valid = 1'b1;
        #1;
        check("a256_ready", req1_ready, 1);
        push(1);
        tick();
        req1_valid = 1'b0;
        #1;
        check("a256_next", eng_next, 1);
        check("a256_keylen", eng_keylen, 1);
        repeat (5) tick();
        check("a256_hold", {eng_keylen, eng_block}, {1'b1, CT256});
        run(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_decipher_arbiter.md
# aes_decipher_arbiter

Shares a single `aes_decipher_block` round engine between two requesters: requester 0 and requester 1. Each requester submits a 128-bit ciphertext block plus a key length. The arbiter grants one request at a time in round-robin order, registers the operands, and pulses `next` to the engine. It then waits for the engine to finish and returns the plaintext on a shared valid/ready response channel tagged with the requester ID. A watchdog reports an error if the engine fails to complete.

## Interface
- `TIMEOUT`, default 255: maximum number of wait cycles after `next` before the error response (minimum 100; the worst case is AES-256).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a block to decipher.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_block` in 128: ciphertext for requester 0.
- `req0_keylen` in 1: 0 = AES-128, 1 = AES-256.
- `req1_valid`, `req1_ready`, `req1_block`, `req1_keylen`: same as the requester 0 ports, for requester 1.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumer accepts.
- `rsp_id` out 1: requester that owns the response.
- `rsp_block` out 128: plaintext (0 on error).
- `rsp_error` out 1: engine timed out.
- `eng_next` out 1: single-cycle start pulse to the engine.
- `eng_keylen` out 1: registered keylen, held for the whole operation.
- `eng_block` out 128: registered ciphertext, held for the whole operation.
- `eng_new_block` in 128: engine result.
- `eng_ready` in 1: engine idle/done flag (registered inside the engine).

## Operation
- The FSM has five states: IDLE, START, WAIT, RESP, ERR_RESP.
- **IDLE**
  - `reqN_ready` is asserted combinationally only for the granted requester, and only when `eng_ready` = 1.
  - If both `reqN_valid` are high, grant the requester that is not `last_grant`.
  - On acceptance: capture block, keylen and ID; update `last_grant`; go to START.
- **START**
  - Assert `eng_next` = 1 for exactly one cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- **WAIT**
  - The watchdog counter increments every cycle.
  - If `eng_ready` = 1: capture `eng_new_block` into `rsp_block`; go to RESP.
  - Otherwise, if the counter equals `TIMEOUT`: set `rsp_block` = 0; go to ERR_RESP.
- **RESP / ERR_RESP**
  - `rsp_valid` = 1, with `rsp_error` = 0 in RESP and 1 in ERR_RESP.
  - `rsp_id` holds the captured ID.
  - Hold all response outputs stable until `rsp_ready` = 1, then go to IDLE.
  - No new request is accepted while in these states.
- `last_grant` resets to 1, so requester 0 wins the first contention.
- The watchdog counter width is $clog2(`TIMEOUT`+1) bits and saturates; it never wraps.
- `eng_block` and `eng_keylen` are unchanged from acceptance until the next acceptance. The engine samples keylen in its idle cycle and block in its init cycle, so both must stay stable across the operation.
- **Reset** (at any time, including mid-operation)
  - FSM → IDLE.
  - All outputs 0: `rsp_valid`, `rsp_error`, `rsp_id`, `rsp_block`, `eng_next`, `eng_keylen`, `eng_block`, `req*_ready`.
  - The engine is reset by the same top-level reset (inverted to its `reset_n`), so no engine operation survives.
- **Simultaneous events**
  - A `reqN_valid` arriving during RESP waits; it is never dropped and is acceptable in the cycle after the response handshake.
  - `eng_ready` = 1 in the same WAIT cycle that the counter hits `TIMEOUT`: the success path takes priority.

## Timing
- Request handshake at cycle t → `eng_next` = 1 at t+1.
- The engine drops `eng_ready` at t+2; the first WAIT cycle is t+2.
- `eng_ready` seen high in cycle r → `rsp_valid` = 1 from r+1.
- Arbiter overhead is 3 cycles beyond the engine latency: accept → START → result capture.
- Response handshake at cycle h → IDLE at h+1, with the next `req_ready` possible at h+1.
- Back-to-back throughput is one operation per engine latency + 4 cycles.

## Structure
- Shared package `aes_arb_pkg` holds:
  - FSM state encodings (3-bit localparams);
  - `AES_128_BIT_KEY` and `AES_256_BIT_KEY`;
  - requester ID width.
- One natural sub-module, `aes_rr_arb2`: a 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: one-hot `grant`, `grant_id`.
  - Purely combinational; the `last_grant` register lives in the parent.
- The engine is instantiated at the top level, next to the arbiter, not inside it.

## Test plan
- **Single request:** `req0` with block 69c4e0d86a7b0430d8cdb78070b4c55a, keylen 0, FIPS-197 AES-128 key → `eng_next` pulses once at t+1; response `rsp_id` = 0, `rsp_block` = 00112233445566778899aabbccddeeff, `rsp_error` = 0.
- **Contention:** `req0` and `req1` valid in the same cycle from reset → requester 0 is served first, then requester 1. A further simultaneous request is then granted to requester 0 (alternation holds).
- **Backpressure:** hold `rsp_ready` = 0 for 20 cycles → `rsp_valid`, `rsp_block` and `rsp_id` remain stable; `req1_ready` stays 0 until the cycle after the handshake.
- **Timeout:** `TIMEOUT` = 100, engine model holds `eng_ready` = 0 → exactly 100 WAIT cycles, then `rsp_valid` = 1, `rsp_error` = 1, `rsp_block` = 0.
- **Reset mid-operation:** assert `reset` during WAIT → outputs 0 immediately (asynchronously), FSM in IDLE; a fresh AES-256 request afterward (keylen 1) completes correctly.
